// File: rtl/vga_timing_gen_if.sv
// Screen interface between the raster source and the game controllers:
// pixel coordinates and frame tick out, registered colour back.
interface vga_timing_gen_if;
    logic [9:0] screenX;
    logic [8:0] screenY;
    logic       refresh;
    logic [3:0] r_in;
    logic [3:0] g_in;
    logic [3:0] b_in;

    modport master (
        output screenX,
        output screenY,
        output refresh,
        input  r_in,
        input  g_in,
        input  b_in
    );

    modport slave (
        input  screenX,
        input  screenY,
        input  refresh,
        output r_in,
        output g_in,
        output b_in
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: counters, coordinates, frame tick,
// and a delay line that re-aligns sync/blanking with returned colour.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic              vga_clock,
    input  logic              reset,
    vga_timing_gen_if.master  scr,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              hsync,
    output logic              vsync,
    output logic              active
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DW    = (SYNC_DELAY > 0) ? SYNC_DELAY : 1;

    localparam logic [9:0] H_LAST = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [9:0]    hcount_q, hcount_d;
    logic [9:0]    vcount_q, vcount_d;
    logic          refresh_q, refresh_d;
    logic [DW-1:0] vis_pipe_q, vis_pipe_d;
    logic [DW-1:0] hs_pipe_q, hs_pipe_d;
    logic [DW-1:0] vs_pipe_q, vs_pipe_d;
    logic [11:0]   rgb_q, rgb_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;

    logic vis;
    logic hs_raw;
    logic vs_raw;
    logic vis_dly;
    logic hs_dly;
    logic vs_dly;

    assign vis    = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    assign hs_raw = !((hcount_q >= HS_BEG) && (hcount_q <= HS_END));
    assign vs_raw = !((vcount_q >= VS_BEG) && (vcount_q <= VS_END));

    assign scr.screenX = vis ? hcount_q : 10'd0;
    assign scr.screenY = vis ? vcount_q[8:0] : 9'd0;
    assign scr.refresh = refresh_q;

    always_comb begin
        hcount_d = hcount_q + 10'd1;
        vcount_d = vcount_q;
        if (hcount_q == H_LAST) begin
            hcount_d = 10'd0;
            vcount_d = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
        end
        // Track the next line so the tick flop lines up with vcount.
        refresh_d = (vcount_d == V_VIS);
    end

    always_comb begin
        vis_pipe_d    = vis_pipe_q;
        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        vis_pipe_d[0] = vis;
        hs_pipe_d[0]  = hs_raw;
        vs_pipe_d[0]  = vs_raw;
        for (int i = 1; i < DW; i++) begin
            vis_pipe_d[i] = vis_pipe_q[i-1];
            hs_pipe_d[i]  = hs_pipe_q[i-1];
            vs_pipe_d[i]  = vs_pipe_q[i-1];
        end
        vis_dly = (SYNC_DELAY == 0) ? vis    : vis_pipe_q[DW-1];
        hs_dly  = (SYNC_DELAY == 0) ? hs_raw : hs_pipe_q[DW-1];
        vs_dly  = (SYNC_DELAY == 0) ? vs_raw : vs_pipe_q[DW-1];
        rgb_d    = vis_dly ? {scr.r_in, scr.g_in, scr.b_in} : 12'd0;
        hsync_d  = hs_dly;
        vsync_d  = vs_dly;
        active_d = vis_dly;
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            hcount_q   <= 10'd0;
            vcount_q   <= 10'd0;
            refresh_q  <= 1'b0;
            vis_pipe_q <= '0;
            hs_pipe_q  <= '1;
            vs_pipe_q  <= '1;
            rgb_q      <= 12'd0;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            active_q   <= 1'b0;
        end else begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            refresh_q  <= refresh_d;
            vis_pipe_q <= vis_pipe_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            rgb_q      <= rgb_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            active_q   <= active_d;
        end
    end

    assign vga_r  = rgb_q[11:8];
    assign vga_g  = rgb_q[7:4];
    assign vga_b  = rgb_q[3:0];
    assign hsync  = hsync_q;
    assign vsync  = vsync_q;
    assign active = active_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a shortened vertical frame (15 lines)
// so several frames and a mid-frame reset fit in a short run.
module tb_vga_timing_gen;

    localparam int HT  = 800;
    localparam int VA  = 8;
    localparam int VFP = 2;
    localparam int VSY = 2;
    localparam int VBP = 3;
    localparam int VT  = VA + VFP + VSY + VBP;
    localparam int FT  = HT * VT;
    localparam int SD  = 1;

    logic clk = 1'b0;
    logic reset;
    logic [3:0] vr, vg, vb;
    logic hsync, vsync, active;

    always #20 clk = ~clk;

    vga_timing_gen_if scr ();

    vga_timing_gen #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .SYNC_DELAY(SD)
    ) dut (
        .vga_clock(clk),
        .reset(reset),
        .scr(scr),
        .vga_r(vr),
        .vga_g(vg),
        .vga_b(vb),
        .hsync(hsync),
        .vsync(vsync),
        .active(active)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ncyc = 0;
    logic chk_en = 1'b0;
    logic phase_b = 1'b0;
    logic mid_done = 1'b0;
    logic done = 1'b0;
    logic fin = 1'b0;
    logic lit0 = 1'b0;
    logic lit1 = 1'b0;
    logic [11:0] smp = 12'd0;

    // cyc = cycles since the last reset edge = pixel index presented
    always @(posedge clk) begin
        smp <= {scr.r_in, scr.g_in, scr.b_in};
        cyc <= reset ? 0 : cyc + 1;
    end

    task automatic chk(input string nm, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h",
                     nm, cyc, act, exp);
        end
    endtask

    function automatic logic vis_at(int p);
        return ((p % HT) < 640) && (((p / HT) % VT) < VA);
    endfunction

    logic prev_hs = 1'b1, prev_vs = 1'b1, prev_ref = 1'b0;
    logic [8:0] prev_sy = 9'd0;
    logic [11:0] prev_rgb = 12'd0;
    int m_hs = -1, m_vs = -1, m_ref = -1, m_639 = -1, m_sy = -1;
    int run_st = -1;
    int n_hs = 0, n_vs = 0, n_ref = 0, n_ref_post = 0;
    int n_run = 0, n_sx = 0, n_sy = 0;

    always @(negedge clk) begin
        int h, v, p, ph, pv;
        logic vis, er, ehs, evs, eact;
        logic [9:0] ex;
        logic [8:0] ey;
        logic [11:0] ergb, rgb;
        if (chk_en) begin
            rgb = {vr, vg, vb};
            h = cyc % HT;
            v = (cyc / HT) % VT;
            vis = vis_at(cyc);
            ex = vis ? 10'(h) : 10'd0;
            ey = vis ? 9'(v) : 9'd0;
            er = (v == VA);
            if (cyc < SD + 1) begin
                ehs = 1'b1; evs = 1'b1; eact = 1'b0; ergb = 12'd0;
            end else begin
                p = cyc - SD - 1;
                ph = p % HT;
                pv = (p / HT) % VT;
                eact = vis_at(p);
                ehs = !(ph >= 656 && ph <= 751);
                evs = !(pv >= VA + VFP && pv <= VA + VFP + VSY - 1);
                ergb = eact ? smp : 12'd0;
            end
            chk("model",
                {ex, ey, er, ehs, evs, eact, ergb} ==
                {scr.screenX, scr.screenY, scr.refresh, hsync, vsync, active, rgb},
                {scr.screenX, scr.screenY, scr.refresh, hsync, vsync, active, rgb},
                {ex, ey, er, ehs, evs, eact, ergb});

            if (!reset && cyc == 0 && !lit0) begin
                lit0 = 1'b1;
                chk("rst_sync", hsync && vsync, {hsync, vsync}, 2'b11);
                chk("rst_rgb", rgb == 12'd0, rgb, 0);
                chk("rst_refresh", !scr.refresh, scr.refresh, 0);
                chk("rst_active", !active, active, 0);
                chk("rst_xy", scr.screenX == 0 && scr.screenY == 0,
                    {scr.screenX, scr.screenY}, 0);
            end else if (lit0 && !lit1 && cyc == 1) begin
                lit1 = 1'b1;
                chk("rst_x1", scr.screenX == 10'd1, scr.screenX, 1);
            end

            if (reset) begin
                m_hs = -1; m_vs = -1; m_ref = -1; m_639 = -1; m_sy = -1;
            end

            if (prev_hs && !hsync) begin
                n_hs++;
                chk("hs_phase", (cyc % HT) == 658, cyc % HT, 658);
                if (m_hs >= 0) chk("hs_period", ncyc - m_hs == 800, ncyc - m_hs, 800);
                m_hs = ncyc;
            end
            if (!prev_hs && hsync && m_hs >= 0)
                chk("hs_width", ncyc - m_hs == 96, ncyc - m_hs, 96);

            if (prev_vs && !vsync) begin
                n_vs++;
                chk("vs_phase", (cyc % FT) == 8002, cyc % FT, 8002);
                if (m_vs >= 0) chk("vs_period", ncyc - m_vs == FT, ncyc - m_vs, FT);
                m_vs = ncyc;
            end
            if (!prev_vs && vsync && m_vs >= 0)
                chk("vs_width", ncyc - m_vs == 1600, ncyc - m_vs, 1600);

            if (!prev_ref && scr.refresh) begin
                n_ref++;
                if (mid_done) n_ref_post++;
                chk("ref_phase", (cyc % FT) == 6400, cyc % FT, 6400);
                m_ref = ncyc;
            end
            if (prev_ref && !scr.refresh && m_ref >= 0)
                chk("ref_width", ncyc - m_ref == 800, ncyc - m_ref, 800);

            if (!phase_b) begin
                if (rgb == 12'hFFF && prev_rgb != 12'hFFF) begin
                    n_run++;
                    chk("rgb_start", (cyc % HT) == 2, cyc % HT, 2);
                    run_st = ncyc;
                end
                if (rgb != 12'hFFF && prev_rgb == 12'hFFF && run_st >= 0) begin
                    chk("rgb_len", ncyc - run_st == 640, ncyc - run_st, 640);
                    run_st = -1;
                end
            end

            if (scr.screenX == 10'd639 && scr.screenY != 9'(VA - 1)) m_639 = ncyc;
            if (scr.screenX == 10'd1 && m_639 >= 0) begin
                n_sx++;
                chk("sx_wrap", ncyc - m_639 == 162, ncyc - m_639, 162);
                m_639 = -1;
            end
            if (prev_sy == 9'(VA - 1) && scr.screenY == 9'd0) m_sy = ncyc;
            if (scr.screenY == 9'd1 && m_sy >= 0) begin
                n_sy++;
                chk("sy_wrap", ncyc - m_sy == 6560, ncyc - m_sy, 6560);
                m_sy = -1;
            end

            if (done && !fin) begin
                fin = 1'b1;
                chk("n_hs", n_hs >= 40, n_hs, 40);
                chk("n_vs", n_vs == 2, n_vs, 2);
                chk("n_ref", n_ref == 3, n_ref, 3);
                chk("n_ref_post", n_ref_post == 1, n_ref_post, 1);
                chk("n_rgb_runs", n_run == 16, n_run, 16);
                chk("n_sx_wrap", n_sx >= 20, n_sx, 20);
                chk("n_sy_wrap", n_sy == 2, n_sy, 2);
                chk("lit_seen", lit0 && lit1, {lit0, lit1}, 2'b11);
            end

            prev_hs = hsync;
            prev_vs = vsync;
            prev_ref = scr.refresh;
            prev_sy = scr.screenY;
            prev_rgb = rgb;
            ncyc++;
        end
    end

    initial begin
        logic stop;
        stop = 1'b0;
        reset = 1'b1;
        scr.r_in = 4'hF;
        scr.g_in = 4'hF;
        scr.b_in = 4'hF;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 60000 && !stop; k++) begin
            @(posedge clk);
            #1;
            if (!phase_b && cyc >= 20700) phase_b = 1'b1;
            if (phase_b) {scr.r_in, scr.g_in, scr.b_in} = 12'($urandom);
            if (phase_b && !mid_done && cyc == 28400) begin
                reset = 1'b1;
                mid_done = 1'b1;
            end else begin
                reset = 1'b0;
            end
            if (mid_done && !reset && cyc >= 7000) stop = 1'b1;
        end
        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
